// File: rtl/rf_wb_arbiter_if.sv
// Register-file writeback bus between the two writeback sources and the arbiter.
//
// Signals:
//   in0_valid/in0_addr/in0_data  pipeline writeback request (no backpressure)
//   in1_valid/in1_addr/in1_data  multi-cycle unit request
//   in1_ready                    arbiter can accept a source-1 request
//   pipe_stall                   pipeline must hold its in0 request
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
//   wb_idle                      nothing buffered and no write in flight
//
// Modports: master = sources + register file side, slave = arbiter.
interface rf_wb_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          in0_valid;
    logic [AW-1:0] in0_addr;
    logic [DW-1:0] in0_data;
    logic          in1_valid;
    logic          in1_ready;
    logic [AW-1:0] in1_addr;
    logic [DW-1:0] in1_data;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          wb_idle;

    modport master (
        output in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
        input  in1_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, wb_idle
    );

    modport slave (
        input  in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
        output in1_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, wb_idle
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between the main pipeline writeback (source 0,
// fixed priority) and a multi-cycle unit (source 1, buffered in a 2-entry FIFO). A buffered
// entry that keeps losing to source 0 for STARVE_LIMIT cycles forces a pipeline stall so it
// can drain.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   wb             rf_wb_arbiter_if.slave (requests in, write port / stall / idle out)
//   conflict_cnt   (RF_WB_PERF_EN only) cycles with in0_valid and a non-empty buffer
//   stall_cnt      (RF_WB_PERF_EN only) cycles with pipe_stall high
//
// Optional feature macro: RF_WB_PERF_EN adds the two performance counters.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 5,
    parameter int unsigned DW           = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    rf_wb_arbiter_if.slave wb
`ifdef RF_WB_PERF_EN
    ,
    output logic [31:0]  conflict_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [AW-1:0] addr_mem [2];
    logic [DW-1:0] data_mem [2];

    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          force_q, force_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;

    logic          buf_ne;
    logic          push;
    logic          grant_buf;
    logic          grant_in0;
    logic          wr_idx;

    // Ready depends only on registered occupancy (and reset), never on in1_valid.
    assign wb.in1_ready  = rst_n & (count_q != 2'd2);
    assign wb.pipe_stall = force_q;
    assign wb.rf_we      = rf_we_q;
    assign wb.rf_waddr   = rf_waddr_q;
    assign wb.rf_wdata   = rf_wdata_q;
    assign wb.wb_idle    = ~buf_ne & ~rf_we_q;

    always_comb begin
        buf_ne    = (count_q != 2'd0);
        push      = wb.in1_valid & wb.in1_ready;
        grant_buf = buf_ne & (force_q | ~wb.in0_valid);
        // While stalled the pipeline re-presents in0 next cycle, so it is not consumed here.
        grant_in0 = wb.in0_valid & ~force_q & ~grant_buf;
        // Tail slot: push only happens with count 0 or 1, so tail = head + count.
        wr_idx    = rd_ptr_q ^ count_q[0];

        rd_ptr_d  = rd_ptr_q ^ grant_buf;
        count_d   = 2'(count_q + {1'b0, push} - {1'b0, grant_buf});

        starve_d = starve_q;
        if (grant_buf) begin
            starve_d = 4'd0;
        end else if (grant_in0 && buf_ne && (starve_q != Limit)) begin
            starve_d = starve_q + 4'd1;
        end

        force_d = force_q;
        if (grant_buf) begin
            force_d = 1'b0;
        end else if (starve_d == Limit) begin
            force_d = 1'b1;
        end

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_buf) begin
            rf_we_d    = (addr_mem[rd_ptr_q] != '0);
            rf_waddr_d = addr_mem[rd_ptr_q];
            rf_wdata_d = data_mem[rd_ptr_q];
        end else if (grant_in0) begin
            rf_we_d    = (wb.in0_addr != '0);
            rf_waddr_d = wb.in0_addr;
            rf_wdata_d = wb.in0_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            starve_q   <= 4'd0;
            force_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            force_q    <= force_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= wb.in1_addr;
            data_mem[wr_idx] <= wb.in1_data;
        end
    end

`ifdef RF_WB_PERF_EN
    logic [31:0] conflict_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            if (wb.in0_valid && buf_ne) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if (force_q) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule
